gpu_prom_loader: RTL



---
 rtl/gpu_prom_loader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/gpu_prom_loader.sv
// gpu_prom_loader: buffers CPU byte writes for the four colour/lookup PROM RAMs
// and replays them to the PROM write port, by default only during vertical
// blanking so palette updates never tear mid-frame.
// Optional feature: define GPU_PROM_LOADER_SUM_EN to add an 8-bit running sum
// of every strobed PROM byte, readable through reg_rd[1].
module gpu_prom_loader #(
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter bit EOF_ONLY        = 1'b1
) (
  input  logic       bus_clk,
  input  logic       bus_rst_n,
  input  logic       bus_eof,
  input  logic [3:0] cfg_prom_wren,
  input  logic [1:0] reg_wr,
  input  logic [1:0] reg_rd,
  input  logic [7:0] reg_wdata,
  output logic [7:0] reg_rdata,
  output logic [7:0] prom_addr,
  output logic [7:0] prom_wdata,
  output logic [3:0] prom_we,
  output logic       busy
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] PTR_ONE = 1;

  // One queued PROM write; the select is captured per entry so later
  // changes to cfg_prom_wren never retarget bytes already queued.
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic [3:0] sel;
  } entry_t;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    r_addr;
  logic          overflow;
  state_t        state;
  logic [3:0]    sel_q;
  logic [7:0]    sum_val;

  logic       empty, full, data_wr, push, pop;
  logic [3:0] count_sat;
  logic [7:0] status;
  entry_t     head;

  // Queue bookkeeping and the read-status word, all derived from registers.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    count_sat = 4'(count);
    if (int'(count) > 15) count_sat = 4'hF;
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    data_wr = reg_wr[0] && (cfg_prom_wren != 4'h0);
    push    = data_wr && !full;
    pop     = (state == IDLE) && !empty && (bus_eof || !EOF_ONLY);
    busy    = !empty || (state != IDLE);
    head    = mem[rd_ptr];
    status  = {overflow, busy, empty, full, count_sat};
  end

  // FIFO storage; entries are only ever read after being written.
  always_ff @(posedge bus_clk) begin
    // NOTE: the storage array has no reset; the empty count guards it and a reset port would only cost flops.
    if (push) mem[wr_ptr] <= '{addr: r_addr, data: reg_wdata, sel: cfg_prom_wren};
  end

  // FIFO pointers and occupancy; full is judged on the pre-cycle count.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!bus_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // CPU address register: an address write beats the data-write increment,
  // and dropped (overflowing) writes still advance the address.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n)     r_addr <= 8'h00;
    else if (reg_wr[1]) r_addr <= reg_wdata;
    else if (data_wr)   r_addr <= r_addr + 8'd1;
  end

  // Sticky overflow flag: set by a dropped write, cleared by a status read;
  // a set in the same cycle as the clear wins.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n)            overflow <= 1'b0;
    else if (data_wr && full)  overflow <= 1'b1;
    else if (reg_rd[0])        overflow <= 1'b0;
  end

  // Drain FSM: four cycles per entry with a single-cycle write strobe, addr
  // and data held steady around it and kept while idle.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state      <= IDLE;
      sel_q      <= 4'h0;
      prom_addr  <= 8'h00;
      prom_wdata <= 8'h00;
      prom_we    <= 4'h0;
    end else begin
      unique case (state)
        IDLE: begin
          prom_we <= 4'h0;
          if (pop) begin
            prom_addr  <= head.addr;
            prom_wdata <= head.data;
            sel_q      <= head.sel;
            state      <= SETUP;
          end
        end
        SETUP: begin
          prom_we <= sel_q;
          state   <= STROBE;
        end
        STROBE: begin
          prom_we <= 4'h0;
          state   <= HOLD;
        end
        HOLD: begin
          prom_we <= 4'h0;
          state   <= IDLE;
        end
        default: begin
          prom_we <= 4'h0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef GPU_PROM_LOADER_SUM_EN
  logic [7:0] sum;

  // Running checksum of strobed bytes; an address write clears it and
  // takes priority over a strobe in the same cycle.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n)         sum <= 8'h00;
    else if (reg_wr[1])     sum <= 8'h00;
    else if (state == STROBE) sum <= sum + prom_wdata;
  end

  assign sum_val = sum;
`else
  assign sum_val = 8'h00;
`endif

  // Registered AND-OR read mux: zero when nothing is read, OR of both sources
  // when both strobes are set.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) reg_rdata <= 8'h00;
    else            reg_rdata <= ({8{reg_rd[0]}} & status) | ({8{reg_rd[1]}} & sum_val);
  end

endmodule
